// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types and constants for the junction sequencer: phase codes, lamp patterns,
// display time width and the saturation helper used by both remaining-time outputs.
package traffic_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    HW_GRN = 3'd0,
    HW_YEL = 3'd1,
    RED1   = 3'd2,
    CR_GRN = 3'd3,
    CR_YEL = 3'd4,
    RED2   = 3'd5,
    FLASH  = 3'd6
  } phase_e;

  localparam logic [2:0] LED_R   = 3'b100;
  localparam logic [2:0] LED_Y   = 3'b010;
  localparam logic [2:0] LED_G   = 3'b001;
  localparam logic [2:0] LED_OFF = 3'b000;

  localparam int TIME_W   = 7;
  localparam int TIME_MAX = 99;

  // Display decoders only handle two digits, so clamp the 9-bit sums.
  function automatic logic [TIME_W-1:0] sat_time(input logic [8:0] v);
    return (v > 9'(TIME_MAX)) ? TIME_W'(TIME_MAX) : v[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_tick_prescaler.sv
// Divides the system clock down to the one-second tick; tick is high for the single
// cycle in which the prescaler sits at TICK_DIV-1.
module traffic_phase_sequencer_tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (tick) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Highway / country-road junction sequencer: one FSM and one shared seconds countdown
// drive both lamp sets and both remaining-time displays, with CR demand and maint flash.
module traffic_phase_sequencer
  import traffic_phase_sequencer_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int HW_GREEN_MIN = 20,
  parameter int CR_GREEN_MIN = 3,
  parameter int CR_GREEN_MAX = 10,
  parameter int YELLOW_T     = 3,
  parameter int ALL_RED_T    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sensor,
  input  logic              maint,
  output logic [2:0]        hw_led,
  output logic [2:0]        cr_led,
  output logic [TIME_W-1:0] hw_time,
  output logic [TIME_W-1:0] cr_time,
  output logic [2:0]        phase
);

  phase_e            state_q, state_d;
  logic [TIME_W-1:0] cnt_q, cnt_d, cnt_dec;
  logic              flash_q, flash_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  logic              tick, sensor_s, cr_min_met;
  logic [8:0]        cnt9, hw_sum, cr_sum;

  traffic_phase_sequencer_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign sensor_s   = sync2_q;
  assign cnt_dec    = (cnt_q == '0) ? '0 : cnt_q - TIME_W'(1);
  // Elapsed CR green (MAX - cnt) has reached the minimum.
  assign cr_min_met = ({1'b0, cnt_q} + 8'(CR_GREEN_MIN)) <= 8'(CR_GREEN_MAX);

  always_comb begin
    sync1_d = sensor;
    sync2_d = sync1_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    if (tick) begin
      cnt_d = cnt_dec;
      if (maint && state_q != FLASH) begin
        state_d = FLASH;
        cnt_d   = '0;
        flash_d = 1'b1;
      end else begin
        case (state_q)
          HW_GRN: begin
            if (cnt_q <= TIME_W'(1)) begin
              if (sensor_s) begin
                state_d = HW_YEL;
                cnt_d   = TIME_W'(YELLOW_T);
              end else begin
                cnt_d = '0;
              end
            end
          end
          HW_YEL: if (cnt_q == TIME_W'(1)) begin
            state_d = RED1;
            cnt_d   = TIME_W'(ALL_RED_T);
          end
          RED1: if (cnt_q == TIME_W'(1)) begin
            state_d = CR_GRN;
            cnt_d   = TIME_W'(CR_GREEN_MAX);
          end
          CR_GRN: if (cnt_q == TIME_W'(1) || (!sensor_s && cr_min_met)) begin
            state_d = CR_YEL;
            cnt_d   = TIME_W'(YELLOW_T);
          end
          CR_YEL: if (cnt_q == TIME_W'(1)) begin
            state_d = RED2;
            cnt_d   = TIME_W'(ALL_RED_T);
          end
          RED2: if (cnt_q == TIME_W'(1)) begin
            state_d = HW_GRN;
            cnt_d   = TIME_W'(HW_GREEN_MIN);
          end
          FLASH: begin
            if (!maint) begin
              state_d = RED2;
              cnt_d   = TIME_W'(ALL_RED_T);
            end else begin
              flash_d = !flash_q;
            end
          end
          default: begin
            state_d = RED2;
            cnt_d   = TIME_W'(ALL_RED_T);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HW_GRN;
      cnt_q   <= TIME_W'(HW_GREEN_MIN);
      flash_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Remaining-time values are upper bounds: RED1 assumes CR green runs to its maximum.
  always_comb begin
    cnt9   = {2'b00, cnt_q};
    hw_led = LED_R;
    cr_led = LED_R;
    hw_sum = '0;
    cr_sum = '0;
    case (state_q)
      HW_GRN: begin
        hw_led = LED_G;
        hw_sum = cnt9;
        cr_sum = (cnt_q == '0) ? 9'd0 : cnt9 + 9'(YELLOW_T + ALL_RED_T);
      end
      HW_YEL: begin
        hw_led = LED_Y;
        hw_sum = cnt9 + 9'(ALL_RED_T);
        cr_sum = cnt9 + 9'(ALL_RED_T);
      end
      RED1: begin
        hw_sum = cnt9 + 9'(CR_GREEN_MAX + YELLOW_T + ALL_RED_T);
        cr_sum = cnt9;
      end
      CR_GRN: begin
        cr_led = LED_G;
        hw_sum = cnt9 + 9'(YELLOW_T + ALL_RED_T);
        cr_sum = cnt9;
      end
      CR_YEL: begin
        cr_led = LED_Y;
        hw_sum = cnt9 + 9'(ALL_RED_T);
        cr_sum = cnt9;
      end
      RED2: begin
        hw_sum = cnt9;
        cr_sum = cnt9 + 9'(HW_GREEN_MIN + YELLOW_T + ALL_RED_T);
      end
      FLASH: begin
        hw_led = flash_q ? LED_Y : LED_OFF;
        cr_led = flash_q ? LED_Y : LED_OFF;
      end
      default: ;
    endcase
    hw_time = sat_time(hw_sum);
    cr_time = sat_time(cr_sum);
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer with a one-cycle tick: directed vectors push
// hand-computed expectations, a monitor pops and compares them and checks lamp invariants.
module tb_traffic_phase_sequencer;
  import traffic_phase_sequencer_pkg::*;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;
  localparam logic [2:0] L_O = 3'b000;

  typedef struct {
    int         step;
    logic [2:0] ph;
    logic [2:0] hwLed;
    logic [2:0] crLed;
    logic [6:0] hwTime;
    logic [6:0] crTime;
  } expect_t;

  logic       clk;
  logic       rst;
  logic       sensor;
  logic       maint;
  logic [2:0] hw_led;
  logic [2:0] cr_led;
  logic [6:0] hw_time;
  logic [6:0] cr_time;
  logic [2:0] phase;

  expect_t expQ[$];
  int      compared   = 0;
  int      mismatched = 0;
  int      stepNo     = 0;
  bit      done       = 1'b0;

  traffic_phase_sequencer #(
    .TICK_DIV    (1),
    .HW_GREEN_MIN(5),
    .CR_GREEN_MIN(2),
    .CR_GREEN_MAX(6),
    .YELLOW_T    (2),
    .ALL_RED_T   (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sensor (sensor),
    .maint  (maint),
    .hw_led (hw_led),
    .cr_led (cr_led),
    .hw_time(hw_time),
    .cr_time(cr_time),
    .phase  (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs for the coming edge and queue what the outputs must show after it.
  task automatic applyStimulus(input logic r, input logic s, input logic m, input phase_e ph,
                               input logic [2:0] hl, input logic [2:0] cl,
                               input int ht, input int ct);
    expect_t e;
    @(negedge clk);
    rst    = r;
    sensor = s;
    maint  = m;
    stepNo++;
    e.step   = stepNo;
    e.ph     = ph;
    e.hwLed  = hl;
    e.crLed  = cl;
    e.hwTime = 7'(ht);
    e.crTime = 7'(ct);
    expQ.push_back(e);
  endtask

  task automatic compareField(input string what, input int step, input logic [8:0] got,
                              input logic [8:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL step %0d %s: got %0d, expected %0d", step, what, got, want);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    compareField("phase",   e.step, {6'd0, phase},   {6'd0, e.ph});
    compareField("hw_led",  e.step, {6'd0, hw_led},  {6'd0, e.hwLed});
    compareField("cr_led",  e.step, {6'd0, cr_led},  {6'd0, e.crLed});
    compareField("hw_time", e.step, {2'd0, hw_time}, {2'd0, e.hwTime});
    compareField("cr_time", e.step, {2'd0, cr_time}, {2'd0, e.crTime});
  endtask

  task automatic checkInvariants();
    logic legal;
    compared++;
    if (hw_led === L_G && cr_led === L_G) begin
      mismatched++;
      $display("[TB] FAIL invariant both_green: hw_led %b cr_led %b", hw_led, cr_led);
    end
    compared++;
    if (!(hw_time <= 7'd99 && cr_time <= 7'd99)) begin
      mismatched++;
      $display("[TB] FAIL invariant time_range: hw_time %0d cr_time %0d, limit 99", hw_time, cr_time);
    end
    legal = ($onehot(hw_led) && $onehot(cr_led)) ||
            (phase === 3'(FLASH) && (hw_led === L_Y || hw_led === L_O) && cr_led === hw_led);
    compared++;
    if (legal !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL invariant led_encoding: hw_led %b cr_led %b phase %0d", hw_led, cr_led, phase);
    end
  endtask

  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      checkInvariants();
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end else if (done) begin
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: run did not complete within 50000 time units");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst    = 1'b1;
    sensor = 1'b0;
    maint  = 1'b0;

    $display("[TB] reset, then idle HW green without demand");
    applyStimulus(1, 0, 0, HW_GRN, L_G, L_R, 5, 8);
    applyStimulus(1, 0, 0, HW_GRN, L_G, L_R, 5, 8);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 4, 7);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 3, 6);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 2, 5);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 1, 4);
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 0, 0);

    $display("[TB] sensor held high: full cycle with CR green at maximum");
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 0, 0);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 0, 0);
    applyStimulus(0, 1, 0, HW_YEL, L_Y, L_R, 3, 3);
    applyStimulus(0, 1, 0, HW_YEL, L_Y, L_R, 2, 2);
    applyStimulus(0, 1, 0, RED1,   L_R, L_R, 10, 1);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 9, 6);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 8, 5);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 7, 4);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 6, 3);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 5, 2);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 4, 1);
    applyStimulus(0, 1, 0, CR_YEL, L_R, L_Y, 3, 2);
    applyStimulus(0, 1, 0, CR_YEL, L_R, L_Y, 2, 1);
    applyStimulus(0, 1, 0, RED2,   L_R, L_R, 1, 9);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 5, 8);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 4, 7);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 3, 6);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 2, 5);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 1, 4);
    applyStimulus(0, 1, 0, HW_YEL, L_Y, L_R, 3, 3);

    $display("[TB] sensor drops at CR green entry: green ends at minimum");
    applyStimulus(0, 1, 0, HW_YEL, L_Y, L_R, 2, 2);
    applyStimulus(0, 1, 0, RED1,   L_R, L_R, 10, 1);
    applyStimulus(0, 0, 0, CR_GRN, L_R, L_G, 9, 6);
    applyStimulus(0, 0, 0, CR_GRN, L_R, L_G, 8, 5);
    applyStimulus(0, 0, 0, CR_GRN, L_R, L_G, 7, 4);
    applyStimulus(0, 0, 0, CR_YEL, L_R, L_Y, 3, 2);
    applyStimulus(0, 0, 0, CR_YEL, L_R, L_Y, 2, 1);
    applyStimulus(0, 0, 0, RED2,   L_R, L_R, 1, 9);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 5, 8);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 4, 7);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 3, 6);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 2, 5);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 1, 4);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 0, 0);

    $display("[TB] maintenance flash entered from CR green");
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 0, 0);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 0, 0);
    applyStimulus(0, 1, 0, HW_YEL, L_Y, L_R, 3, 3);
    applyStimulus(0, 1, 0, HW_YEL, L_Y, L_R, 2, 2);
    applyStimulus(0, 1, 0, RED1,   L_R, L_R, 10, 1);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 9, 6);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 8, 5);
    applyStimulus(0, 1, 1, FLASH,  L_Y, L_Y, 0, 0);
    applyStimulus(0, 1, 1, FLASH,  L_O, L_O, 0, 0);
    applyStimulus(0, 1, 1, FLASH,  L_Y, L_Y, 0, 0);
    applyStimulus(0, 1, 1, FLASH,  L_O, L_O, 0, 0);
    applyStimulus(0, 1, 0, RED2,   L_R, L_R, 1, 9);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 5, 8);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 4, 7);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 3, 6);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 2, 5);
    applyStimulus(0, 1, 0, HW_GRN, L_G, L_R, 1, 4);
    applyStimulus(0, 1, 0, HW_YEL, L_Y, L_R, 3, 3);
    applyStimulus(0, 1, 0, HW_YEL, L_Y, L_R, 2, 2);
    applyStimulus(0, 1, 0, RED1,   L_R, L_R, 10, 1);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 9, 6);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 8, 5);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 7, 4);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 6, 3);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 5, 2);
    applyStimulus(0, 1, 0, CR_GRN, L_R, L_G, 4, 1);
    applyStimulus(0, 1, 0, CR_YEL, L_R, L_Y, 3, 2);

    $display("[TB] reset pulse during CR yellow");
    applyStimulus(1, 0, 0, HW_GRN, L_G, L_R, 5, 8);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 4, 7);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 3, 6);

    $display("[TB] maintenance flash entered from HW green");
    applyStimulus(0, 0, 1, FLASH,  L_Y, L_Y, 0, 0);
    applyStimulus(0, 0, 0, RED2,   L_R, L_R, 1, 9);
    applyStimulus(0, 0, 0, HW_GRN, L_G, L_R, 5, 8);

    done = 1'b1;
  end

endmodule
